// File: rtl/nibble_serial_adder_ctrl_if.sv
// ============================================================================
// nibble_serial_adder_ctrl_if : operand/result handshake bundle for the
// nibble-serial adder. OVF exists only when SERIAL_ADDER_OVF_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             BUSY;
`ifdef SERIAL_ADDER_OVF_EN
  logic             OVF;

  modport master (
    output IN_VALID, A, B, CIN, OUT_READY,
    input  IN_READY, OUT_VALID, SUM, COUT, BUSY, OVF
  );

  modport slave (
    input  IN_VALID, A, B, CIN, OUT_READY,
    output IN_READY, OUT_VALID, SUM, COUT, BUSY, OVF
  );
`else
  modport master (
    output IN_VALID, A, B, CIN, OUT_READY,
    input  IN_READY, OUT_VALID, SUM, COUT, BUSY
  );

  modport slave (
    input  IN_VALID, A, B, CIN, OUT_READY,
    output IN_READY, OUT_VALID, SUM, COUT, BUSY
  );
`endif
endinterface

`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
// ============================================================================
// nibble_serial_adder_ctrl : WIDTH-bit adder built from one 4-bit slice, one
// nibble per cycle LSB first. Macro SERIAL_ADDER_OVF_EN adds a signed OVF flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  wire logic                     CLK,
  input  wire logic                     ASYNCRESET,
  nibble_serial_adder_ctrl_if.slave     bus
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NIBBLES - 1);

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             out_valid_q;

  logic [4:0]       slice_w;
  logic [WIDTH-1:0] res_d;
  logic             accept_w;
  logic             last_w;

  // The 4-bit slice shared by every nibble.
  assign slice_w = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, carry_q};

  assign bus.IN_READY  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.OUT_READY);
  assign accept_w      = bus.IN_VALID && bus.IN_READY;
  assign last_w        = (cnt_q == C_LAST);
  assign bus.BUSY      = (state_q == S_RUN);
  assign bus.OUT_VALID = out_valid_q;
  assign bus.SUM       = sum_q;
  assign bus.COUT      = cout_q;

  // Partial result: earlier nibbles sit in the low part, the new one enters at the top.
  if (WIDTH > 4) begin : g_res_shift
    logic [WIDTH-5:0] res_q;

    assign res_d = {slice_w[3:0], res_q};

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
        res_q <= '0;
      end else if (state_q == S_RUN) begin
        res_q <= res_d[WIDTH-1:4];
      end
    end
  end else begin : g_res_single
    assign res_d = slice_w[3:0];
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic [3:0] low3_w;
  logic       ovf_q;

  assign low3_w  = {1'b0, a_q[2:0]} + {1'b0, b_q[2:0]} + {3'b0, carry_q};
  assign bus.OVF = ovf_q;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      ovf_q <= 1'b0;
    end else if ((state_q == S_RUN) && last_w) begin
      ovf_q <= low3_w[3] ^ slice_w[4];
    end
  end
`endif

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_w) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            carry_q <= bus.CIN;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> 4;
          b_q     <= b_q >> 4;
          carry_q <= slice_w[4];
          cnt_q   <= cnt_q + 1'b1;
          if (last_w) begin
            sum_q       <= res_d;
            cout_q      <= slice_w[4];
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.OUT_READY) begin
            out_valid_q <= 1'b0;
            if (bus.IN_VALID) begin
              a_q     <= bus.A;
              b_q     <= bus.B;
              carry_q <= bus.CIN;
              cnt_q   <= '0;
              state_q <= S_RUN;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ============================================================================
// tb_nibble_serial_adder_ctrl : directed vectors for nibble_serial_adder_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;

  logic CLK = 1'b0;
  logic ASYNCRESET = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .bus        (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Waits for OUT_VALID after the accepting edge, then checks latency, BUSY and result.
  task automatic wait_result(input string tag, input logic [15:0] exp_sum, input logic exp_cout);
    int lat = 0;
    int busy = 0;
    while (!bus.OUT_VALID && lat < 20) begin
      if (bus.BUSY) busy++;
      tick();
      lat++;
    end
    check_eq({tag, " latency"}, lat, 4);
    check_eq({tag, " busy"}, busy, 4);
    check_eq({tag, " out_valid"}, {31'b0, bus.OUT_VALID}, 1);
    check_eq({tag, " sum"}, {16'b0, bus.SUM}, {16'b0, exp_sum});
    check_eq({tag, " cout"}, {31'b0, bus.COUT}, {31'b0, exp_cout});
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] exp_sum, input logic exp_cout);
    int guard = 0;
    bus.A = a;
    bus.B = b;
    bus.CIN = cin;
    bus.IN_VALID = 1'b1;
    #1;
    while (!bus.IN_READY && guard < 20) begin
      tick();
      guard++;
    end
    check_eq({tag, " in_ready"}, {31'b0, bus.IN_READY}, 1);
    tick();
    bus.IN_VALID = 1'b0;
    wait_result(tag, exp_sum, exp_cout);
  endtask

  initial begin
    bit seen;
    bus.IN_VALID = 1'b1;
    bus.A = 16'h1234;
    bus.B = 16'h4321;
    bus.CIN = 1'b0;
    bus.OUT_READY = 1'b1;

    // Asynchronous reset asserted between clock edges.
    #3 ASYNCRESET = 1'b1;
    #1;
    check_eq("rst out_valid", {31'b0, bus.OUT_VALID}, 0);
    check_eq("rst sum", {16'b0, bus.SUM}, 0);
    check_eq("rst cout", {31'b0, bus.COUT}, 0);
    check_eq("rst busy", {31'b0, bus.BUSY}, 0);
    tick();
    tick();
    bus.IN_VALID = 1'b0;
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    #1;
    check_eq("rst in_ready", {31'b0, bus.IN_READY}, 1);

    run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    tick();
    check_eq("basic consumed", {31'b0, bus.OUT_VALID}, 0);
    check_eq("basic held sum", {16'b0, bus.SUM}, 32'h5555);

    run_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    run_op("msb", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
    check_eq("msb ovf", {31'b0, bus.OVF}, 1);
`endif
    run_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    run_op("pos2neg", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    check_eq("pos2neg ovf", {31'b0, bus.OVF}, 1);
`endif
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
    check_eq("wrap ovf", {31'b0, bus.OVF}, 0);
`endif
    tick();

    // Backpressure: result must hold while OUT_READY is low.
    bus.OUT_READY = 1'b0;
    run_op("bp", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp hold sum", {16'b0, bus.SUM}, 32'h5555);
      check_eq("bp hold valid", {31'b0, bus.OUT_VALID}, 1);
      check_eq("bp in_ready", {31'b0, bus.IN_READY}, 0);
    end
    bus.A = 16'h0001;
    bus.B = 16'h0002;
    bus.CIN = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.OUT_READY = 1'b1;
    #1;
    check_eq("b2b in_ready", {31'b0, bus.IN_READY}, 1);
    tick();
    bus.IN_VALID = 1'b0;
    check_eq("b2b valid drop", {31'b0, bus.OUT_VALID}, 0);
    check_eq("b2b busy", {31'b0, bus.BUSY}, 1);
    wait_result("b2b", 16'h0003, 1'b0);
    tick();

    // Reset after two nibbles of an operation.
    bus.A = 16'hABCD;
    bus.B = 16'h1111;
    bus.CIN = 1'b0;
    bus.IN_VALID = 1'b1;
    tick();
    bus.IN_VALID = 1'b0;
    tick();
    tick();
    #2 ASYNCRESET = 1'b1;
    #1;
    check_eq("midrun busy", {31'b0, bus.BUSY}, 0);
    check_eq("midrun out_valid", {31'b0, bus.OUT_VALID}, 0);
    check_eq("midrun sum", {16'b0, bus.SUM}, 0);
    @(negedge CLK);
    ASYNCRESET = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.OUT_VALID) seen = 1'b1;
    end
    check_eq("midrun no pulse", {31'b0, seen}, 0);
    run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that performs WIDTH-bit additions by time-multiplexing a single 4-bit ripple-carry slice (Adder4 or an equivalent FullAdder chain), one nibble per cycle, LSB first. It uses a valid/ready handshake on both sides and registers the carry between nibbles. It sits between an operand producer and a result consumer wherever area matters more than throughput.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4, otherwise elaboration error
NIBBLES, WIDTH/4, derived (localparam), number of RUN cycles per operation

Ports:
CLK  input  1  clock, rising edge
ASYNCRESET  input  1  asynchronous reset, active-high
IN_VALID  input  1  operands A, B and CIN are valid
IN_READY  output  1  block accepts operands this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
CIN  input  1  carry-in to nibble 0
OUT_VALID  output  1  SUM/COUT hold a completed result
OUT_READY  input  1  consumer accepts the result
SUM  output  WIDTH  registered sum
COUT  output  1  registered carry-out of the top nibble
BUSY  output  1  high in RUN state

Behaviour:
- Clock and reset: one clock, CLK. ASYNCRESET is asynchronous and active-high.
- Reset: asserting ASYNCRESET forces state IDLE immediately, regardless of clock. While asserted: OUT_VALID=0, SUM=0, COUT=0, BUSY=0, nibble counter=0, carry register=0, operand shift registers=0. IN_READY=1 after reset.
- States: IDLE, RUN, DONE.
- IN_READY is combinational: high in IDLE, or in DONE when OUT_READY=1. It is low in RUN. Accept = IN_VALID & IN_READY at a rising edge.
- IDLE: on accept, load A and B into the shift registers, load CIN into the carry register, set counter to 0, go to RUN.
- RUN (lasts exactly NIBBLES cycles), each cycle:
  - The slice adds the low nibbles of the A and B shift registers with the carry register.
  - At the edge: the sum nibble shifts into the top of the result shift register, the carry register takes the slice carry-out, both operand registers shift right by 4, and the counter increments.
  - At the edge where counter == NIBBLES-1: copy the full result register to SUM and the slice carry-out to COUT, set OUT_VALID=1, go to DONE.
  - IN_VALID is ignored in RUN.
- Latency: OUT_VALID rises NIBBLES edges after the accepting edge (4 for WIDTH=16, 1 for WIDTH=4).
- DONE: SUM, COUT and OUT_VALID are held stable until OUT_READY=1 at an edge.
  - On that edge, OUT_VALID drops. If IN_VALID is also high at that edge, the new operands are accepted and the next state is RUN; otherwise the next state is IDLE.
  - Peak throughput: one result per NIBBLES+1 cycles.
- SUM/COUT change only on entry to DONE. Between operations they hold the last result (0 after reset).
- Wrap-around: the sum is modulo 2^WIDTH. The carry out of bit WIDTH-1 appears only on COUT.
- Reset mid-RUN or mid-DONE: the partial or pending result is discarded, with no OUT_VALID pulse. The first operation after reset must be exact.

Optional Feature:
Macro SERIAL_ADDER_OVF_EN.
- Defined: adds output port OVF (1 bit), registered alongside COUT. OVF = slice carry into bit 3 XOR slice carry-out on the final nibble, i.e. two's-complement signed overflow. Reset value 0; held with SUM.
- Undefined: no OVF port and no associated logic. All other behaviour is identical.

Test Plan:
- Reset: assert ASYNCRESET mid-cycle with IN_VALID=1 -> immediately OUT_VALID=0, SUM=0x0000, COUT=0, BUSY=0; after release IN_READY=1.
- Basic add (WIDTH=16): A=0x1234, B=0x4321, CIN=0, OUT_READY=1 -> BUSY high for 4 cycles; OUT_VALID high at the 4th edge after accept; SUM=0x5555, COUT=0.
- Full ripple: A=0xFFFF, B=0x0000, CIN=1 -> SUM=0x0000, COUT=1. Then A=0x8000, B=0x8000, CIN=0 -> SUM=0x0000, COUT=1.
- Backpressure / back-to-back:
  - Hold OUT_READY=0 for 10 cycles after result 0x5555 -> SUM, COUT and OUT_VALID stay stable and IN_READY=0.
  - Then raise OUT_READY with IN_VALID=1, A=0x0001, B=0x0002 -> accepted on the same edge; SUM=0x0003 four edges later.
- Reset mid-RUN: assert ASYNCRESET after 2 nibbles of 0xABCD+0x1111 -> IDLE, no OUT_VALID. Then 0x00FF+0x0001 -> SUM=0x0100, COUT=0.
- OVF (macro defined): 0x7FFF+0x0001 -> OVF=1, COUT=0. 0xFFFF+0x0001 -> OVF=0, COUT=1, SUM=0x0000.
